// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Flag vector layout and the flag derivation from the decide state.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int FLAG_W = 6;

    localparam int EQ  = 0;
    localparam int NEQ = 1;
    localparam int GT  = 2;
    localparam int LT  = 3;
    localparam int GE  = 4;
    localparam int LE  = 5;

    function automatic logic [FLAG_W-1:0] cmp_flags(
        input logic decided,
        input logic gt_r
    );
        logic [FLAG_W-1:0] f;
        f      = '0;
        f[EQ]  = !decided;
        f[NEQ] = decided;
        f[GT]  = decided & gt_r;
        f[LT]  = decided & !gt_r;
        f[GE]  = f[GT] | f[EQ];
        f[LE]  = f[LT] | f[EQ];
        return f;
    endfunction

endpackage

// File: rtl/cmp_bit_deser.sv
// MSB-first shift-in register rebuilding one parallel operand.
// Synchronous clear takes priority over the shift enable.
module cmp_bit_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] par_o
);

    logic [WIDTH-1:0] par_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            par_q <= '0;
        end else if (en_i) begin
            par_q <= {par_q[WIDTH-2:0], bit_i};
        end
    end

    assign par_o = par_q;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial comparator: MSB-first operands in, six relational flags out.
// The first differing bit decides the ordering; later bits only shift in.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             eq,
    output logic             neq,
    output logic             gt,
    output logic             lt,
    output logic             ge,
    output logic             le,
    output logic [WIDTH-1:0] a_par,
    output logic [WIDTH-1:0] b_par
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              decided_q;
    logic              gt_q;
    logic              rvalid_q;
    logic [FLAG_W-1:0] flags_q;
    logic              accept;
    logic              shift_en;
    logic              last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (bit_valid && last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state_q == IDLE) && start;
        shift_en = (state_q == SHIFT) && bit_valid;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // Clearing on accept drops the previous result in the start cycle.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            rvalid_q  <= 1'b0;
            flags_q   <= '0;
        end else if (shift_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (!decided_q && (a_bit != b_bit)) begin
                decided_q <= 1'b1;
                gt_q      <= a_bit;
            end
        end else if (done) begin
            rvalid_q <= 1'b1;
            flags_q  <= cmp_flags(decided_q, gt_q);
        end
    end

    cmp_bit_deser #(.WIDTH(WIDTH)) u_deser_a (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (shift_en),
        .bit_i (a_bit),
        .par_o (a_par)
    );

    cmp_bit_deser #(.WIDTH(WIDTH)) u_deser_b (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (shift_en),
        .bit_i (b_bit),
        .par_o (b_par)
    );

    assign result_valid = rvalid_q;
    assign eq           = flags_q[EQ];
    assign neq          = flags_q[NEQ];
    assign gt           = flags_q[GT];
    assign lt           = flags_q[LT];
    assign ge           = flags_q[GE];
    assign le           = flags_q[LE];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for the serial magnitude comparator.
// Expected flags come from parallel relational operators.
module tb_serial_magnitude_comparator;
    import cmp_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [FLAG_W-1:0] f;
        logic [W-1:0]      a;
        logic [W-1:0]      b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic         busy, done, result_valid;
    logic         eq, neq, gt, lt, ge, le;
    logic [W-1:0] a_par, b_par;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq[$];
    logic rv_prev = 1'b0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_valid    (bit_valid),
        .a_bit        (a_bit),
        .b_bit        (b_bit),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .eq           (eq),
        .neq          (neq),
        .gt           (gt),
        .lt           (lt),
        .ge           (ge),
        .le           (le),
        .a_par        (a_par),
        .b_par        (b_par)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FLAG_W-1:0] ref_flags(
        input logic [W-1:0] a, input logic [W-1:0] b);
        logic [FLAG_W-1:0] f;
        f      = '0;
        f[EQ]  = (a == b);
        f[NEQ] = (a != b);
        f[GT]  = (a > b);
        f[LT]  = (a < b);
        f[GE]  = (a >= b);
        f[LE]  = (a <= b);
        return f;
    endfunction

    function automatic logic [FLAG_W-1:0] dut_flags();
        logic [FLAG_W-1:0] f;
        f      = '0;
        f[EQ]  = eq;
        f[NEQ] = neq;
        f[GT]  = gt;
        f[LT]  = lt;
        f[GE]  = ge;
        f[LE]  = le;
        return f;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (result_valid && !rv_prev) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("flags", dut_flags(), e.f);
                chk("a_par", a_par, e.a);
                chk("b_par", b_par, e.b);
                chk("one_hot", $countones({eq, gt, lt}), 32'd1);
                chk("neq_inv", neq, !eq);
            end
        end
        rv_prev = result_valid;
    end

    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int sb, input int sn,
                           input bit rnd, input bit pert);
        exp_t e;
        int   n;
        e.f = ref_flags(a, b);
        e.a = a;
        e.b = b;
        sbq.push_back(e);
        start = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 32'd1);
        chk("start_clr", {result_valid, dut_flags()}, 32'd0);
        for (int i = 0; i < W; i++) begin
            n = (i == sb) ? sn : 0;
            if (rnd) n = ($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0;
            repeat (n) begin
                bit_valid = 1'b0;
                a_bit = 1'($urandom);
                b_bit = 1'($urandom);
                @(posedge clk); #1;
                if (!rnd) chk("stall_busy", busy, 32'd1);
            end
            bit_valid = 1'b1;
            a_bit = a[W-1-i];
            b_bit = b[W-1-i];
            if (pert && i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        bit_valid = 1'b0;
        chk("done_lat", done, 32'd1);
        if (pert) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse", done, 32'd0);
        if (pert) chk("start_done_ign", busy, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_state", {busy, done, result_valid, dut_flags()}, 32'd0);
        chk("rst_par", {a_par, b_par}, 32'd0);

        run_cmp(4'b0100, 4'b0011, -1, 0, 1'b0, 1'b0);
        run_cmp(4'b0100, 4'b0100, -1, 0, 1'b0, 1'b0);
        run_cmp(4'b0011, 4'b0100, -1, 0, 1'b0, 1'b0);
        run_cmp(4'b1000, 4'b0111, 2, 3, 1'b0, 1'b0);
        run_cmp(4'b0110, 4'b0101, -1, 0, 1'b0, 1'b1);
        run_cmp(4'b1001, 4'b1011, 1, 2, 1'b0, 1'b1);

        // Abort a compare after two bits; nothing is queued for it.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            a_bit = 1'b1;
            b_bit = 1'b0;
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {busy, done, result_valid, dut_flags()}, 32'd0);
        chk("abort_par", {a_par, b_par}, 32'd0);
        @(posedge clk); #1;
        chk("abort_idle", busy, 32'd0);
        run_cmp(4'hF, 4'hE, -1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = ($urandom_range(4) == 0) ? ra : W'($urandom);
            run_cmp(ra, rb, -1, 0, 1'b1, 1'($urandom_range(7) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
